// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight destination registers, stalls ID on
// hazards, and arbitrates pipeline vs. long-latency writebacks onto one RF port.
module reg_scoreboard #(
  parameter int DATA_WIDTH         = 32,
  parameter int REG_MEM_ADDR_WIDTH = 5,
  parameter int LONG_MAX           = 4,
  parameter int STARVE_LIMIT       = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic                          id_valid_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0] id_rd_i,
  input  logic                          id_RegWrite_i,
  input  logic                          id_long_i,
  output logic                          stall_o,
  output logic                          issue_o,

  input  logic                          pipe_wb_valid_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0] pipe_wb_addr_i,
  input  logic [DATA_WIDTH-1:0]         pipe_wb_data_i,
  output logic                          pipe_hold_o,

  input  logic                          long_wb_valid_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0] long_wb_addr_i,
  input  logic [DATA_WIDTH-1:0]         long_wb_data_i,
  output logic                          long_wb_ready_o,

  output logic                          wr_en_o,
  output logic [REG_MEM_ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0]         wr_data_o
);

  localparam int NUM_REGS = 1 << REG_MEM_ADDR_WIDTH;
  localparam int LCW      = $clog2(LONG_MAX + 1);
  localparam int WCW      = $clog2(STARVE_LIMIT + 1);

  localparam logic [LCW-1:0] LONG_MAX_C     = LCW'(LONG_MAX);
  localparam logic [WCW-1:0] STARVE_LIMIT_C = WCW'(STARVE_LIMIT);
  localparam logic [REG_MEM_ADDR_WIDTH-1:0] ADDR_ZERO = '0;

  logic [NUM_REGS-1:0] r_pending;
  logic [LCW-1:0]      r_long_cnt;
  logic [WCW-1:0]      r_wait_cnt;

  logic                w_rs1_hit;
  logic                w_rs2_hit;
  logic                w_rd_hit;
  logic                w_long_full;
  logic                w_hazard;
  logic                w_set;
  logic                w_long_issue;
  logic                w_starve;
  logic                w_sel_long;
  logic                w_sel_pipe;
  logic [NUM_REGS-1:0] w_pending_nxt;

  // Hazard detection looks only at registered pending bits, so a writeback
  // committing this cycle releases its consumers one cycle later.
  assign w_rs1_hit   = r_pending[id_rs1_i] & (id_rs1_i != ADDR_ZERO);
  assign w_rs2_hit   = r_pending[id_rs2_i] & (id_rs2_i != ADDR_ZERO);
  assign w_rd_hit    = id_RegWrite_i & (id_rd_i != ADDR_ZERO) & r_pending[id_rd_i];
  assign w_long_full = id_RegWrite_i & id_long_i & (r_long_cnt == LONG_MAX_C);
  assign w_hazard    = id_valid_i & (w_rs1_hit | w_rs2_hit | w_rd_hit | w_long_full);

  assign stall_o      = w_hazard;
  assign issue_o      = id_valid_i & ~w_hazard;
  assign w_set        = issue_o & id_RegWrite_i & (id_rd_i != ADDR_ZERO);
  assign w_long_issue = issue_o & id_RegWrite_i & id_long_i;

  // Pipeline writeback normally wins; a long writeback that has waited long
  // enough takes the port and the pipeline holds its request.
  assign w_starve        = (r_wait_cnt >= STARVE_LIMIT_C);
  assign long_wb_ready_o = long_wb_valid_i & (~pipe_wb_valid_i | w_starve);
  assign pipe_hold_o     = pipe_wb_valid_i & w_starve & long_wb_valid_i;
  assign w_sel_long      = long_wb_ready_o;
  assign w_sel_pipe      = ~long_wb_ready_o & pipe_wb_valid_i & ~pipe_hold_o;

  always_comb begin
    wr_en_o   = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    if (w_sel_long) begin
      wr_addr_o = long_wb_addr_i;
      wr_data_o = long_wb_data_i;
      wr_en_o   = (long_wb_addr_i != ADDR_ZERO);
    end else if (w_sel_pipe) begin
      wr_addr_o = pipe_wb_addr_i;
      wr_data_o = pipe_wb_data_i;
      wr_en_o   = (pipe_wb_addr_i != ADDR_ZERO);
    end
  end

  // Clear first, then set, so an issue to the register being written back
  // leaves it pending; x0 is never tracked.
  always_comb begin
    w_pending_nxt = r_pending;
    if (wr_en_o) begin
      w_pending_nxt[wr_addr_o] = 1'b0;
    end
    if (w_set) begin
      w_pending_nxt[id_rd_i] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_long_cnt <= '0;
    end else if (w_long_issue && !long_wb_ready_o) begin
      if (r_long_cnt != LONG_MAX_C) begin
        r_long_cnt <= r_long_cnt + 1'b1;
      end
    end else if (!w_long_issue && long_wb_ready_o) begin
      if (r_long_cnt != '0) begin
        r_long_cnt <= r_long_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (long_wb_ready_o) begin
      r_wait_cnt <= '0;
    end else if (long_wb_valid_i && (r_wait_cnt < STARVE_LIMIT_C)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

endmodule
